// File: rtl/heu.sv
// Histogram-equalization unit: gathers a 400-pixel window in 5 beats, builds a 256-bin
// histogram and its CDF, then streams back min-CDF-equalized pixels in 5 beats.
module heu #(
    parameter int PIX_W     = 8,
    parameter int BEAT_PIX  = 80,
    parameter int NUM_BEATS = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               vldIpgu,
    input  logic [BEAT_PIX-1:0][PIX_W-1:0]     ipguOutBufferQ,
    output logic                               rdyHeu,
    output logic                               vldHeu,
    output logic [BEAT_PIX-1:0][PIX_W-1:0]     heuOutBufferQ,
    input  logic                               rdyRnn
);
    localparam int WIN   = BEAT_PIX * NUM_BEATS;
    localparam int NBINS = 1 << PIX_W;
    localparam int CNT_W = $clog2(WIN + 1);
    localparam int NUM_W = CNT_W + PIX_W;
    localparam int BW    = $clog2(NUM_BEATS);
    localparam int PW    = $clog2(BEAT_PIX);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(NUM_BEATS - 1);
    localparam logic [PW-1:0]    LAST_PIX  = PW'(BEAT_PIX - 1);
    localparam logic [PIX_W-1:0] LAST_BIN  = PIX_W'(NBINS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HIST, CDF, MAP, OUT} state_t;

    state_t                                   r_state, w_state_nxt;
    logic [NUM_BEATS-1:0][BEAT_PIX-1:0][PIX_W-1:0] r_win;
    logic [NBINS-1:0][CNT_W-1:0]              r_bin;
    logic [BEAT_PIX-1:0][PIX_W-1:0]           r_out;
    logic [BW-1:0]                            r_beat;
    logic [PW-1:0]                            r_pix;
    logic [PIX_W-1:0]                         r_idx;
    logic [CNT_W-1:0]                         r_acc;
    logic [CNT_W-1:0]                         r_cmin;
    logic                                     r_found;

    logic                                     w_rdy, w_vld;
    logic [BW-1:0]                            w_beat_nxt;
    logic [PW-1:0]                            w_pix_nxt;
    logic                                     w_pix_last;
    logic [PIX_W-1:0]                         w_pix;
    logic [CNT_W-1:0]                         w_acc_nxt;
    logic [CNT_W-1:0]                         w_diff;
    logic [CNT_W-1:0]                         w_den;
    logic [NUM_W-1:0]                         w_num;
    logic [NUM_W-1:0]                         w_quot;
    logic [PIX_W-1:0]                         w_map;

    assign rdyHeu        = w_rdy;
    assign vldHeu        = w_vld;
    assign heuOutBufferQ = r_out;

    assign w_beat_nxt = (r_beat == LAST_BEAT) ? '0 : r_beat + BW'(1);
    assign w_pix_last = (r_pix == LAST_PIX);
    assign w_pix_nxt  = w_pix_last ? '0 : r_pix + PW'(1);
    // The same beat/pixel walk addresses the window for both HIST and MAP.
    assign w_pix      = r_win[r_beat][r_pix];
    assign w_acc_nxt  = r_acc + r_bin[r_idx];

    // Bins hold the CDF once MAP starts; c >= cdf_min for any pixel present.
    assign w_diff = r_bin[w_pix] - r_cmin;
    assign w_den  = CNT_W'(WIN) - r_cmin;
    assign w_num  = NUM_W'(w_diff) * NUM_W'(NBINS - 1);
    assign w_quot = (w_den == '0) ? '0 : w_num / NUM_W'(w_den);
    assign w_map  = w_quot[PIX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = 1'b0;
        w_vld       = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = LOAD;
            LOAD: begin
                w_rdy = 1'b1;
                if (vldIpgu && r_beat == LAST_BEAT) w_state_nxt = HIST;
            end
            HIST: if (w_pix_last && r_beat == LAST_BEAT) w_state_nxt = CDF;
            CDF:  if (r_idx == LAST_BIN) w_state_nxt = MAP;
            MAP:  if (w_pix_last) w_state_nxt = OUT;
            OUT: begin
                w_vld = 1'b1;
                if (rdyRnn) w_state_nxt = (r_beat == LAST_BEAT) ? IDLE : MAP;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_bin   <= '0;
            r_out   <= '0;
            r_beat  <= '0;
            r_pix   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_cmin  <= '0;
            r_found <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bin   <= '0;
                    r_beat  <= '0;
                    r_pix   <= '0;
                    r_idx   <= '0;
                    r_acc   <= '0;
                    r_cmin  <= '0;
                    r_found <= 1'b0;
                end
                LOAD: if (vldIpgu) begin
                    r_win[r_beat] <= ipguOutBufferQ;
                    r_beat        <= w_beat_nxt;
                end
                HIST: begin
                    r_bin[w_pix] <= r_bin[w_pix] + CNT_W'(1);
                    r_pix        <= w_pix_nxt;
                    if (w_pix_last) r_beat <= w_beat_nxt;
                end
                CDF: begin
                    r_bin[r_idx] <= w_acc_nxt;
                    r_acc        <= w_acc_nxt;
                    r_idx        <= r_idx + PIX_W'(1);
                    if (!r_found && w_acc_nxt != '0) begin
                        r_found <= 1'b1;
                        r_cmin  <= w_acc_nxt;
                    end
                end
                MAP: begin
                    r_out[r_pix] <= w_map;
                    r_pix        <= w_pix_nxt;
                end
                OUT: if (rdyRnn) r_beat <= w_beat_nxt;
                default: ;
            endcase
        end
    end

    a_map_range: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == MAP) |-> ((w_quot >> PIX_W) == '0));

endmodule

// File: tb/tb_heu.sv
// Directed bench for heu: constant, two-level and ramp windows, backpressure,
// gapped input pacing and a reset during CDF.
module tb_heu;
    typedef logic [4:0][79:0][7:0] win_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            vldIpgu = 1'b0;
    logic            rdyRnn = 1'b0;
    logic [79:0][7:0] ipguOutBufferQ = '0;
    logic [79:0][7:0] heuOutBufferQ;
    logic            rdyHeu, vldHeu;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, acc_cyc = 0, out_cyc = 0, n_acc = 0, n_out = 0;

    always #5 clk = ~clk;

    heu dut (
        .clk(clk), .rst_n(rst_n), .vldIpgu(vldIpgu), .ipguOutBufferQ(ipguOutBufferQ),
        .rdyHeu(rdyHeu), .vldHeu(vldHeu), .heuOutBufferQ(heuOutBufferQ), .rdyRnn(rdyRnn)
    );

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (vldIpgu && rdyHeu) begin n_acc = n_acc + 1; acc_cyc = cyc; end
        if (vldHeu && rdyRnn)  begin n_out = n_out + 1; out_cyc = cyc; end
    end

    function automatic win_t mk_ramp();
        win_t w;
        for (int i = 0; i < 400; i++) w[i/80][i%80] = 8'(i >> 1);
        return w;
    endfunction
    function automatic win_t exp_ramp();
        win_t w;
        for (int i = 0; i < 400; i++) w[i/80][i%80] = 8'((2 * (i >> 1) * 255) / 398);
        return w;
    endfunction
    function automatic win_t mk_two();
        win_t w;
        for (int i = 0; i < 400; i++) w[i/80][i%80] = (i < 200) ? 8'd10 : 8'd50;
        return w;
    endfunction
    function automatic win_t exp_two();
        win_t w;
        for (int i = 0; i < 400; i++) w[i/80][i%80] = (i < 200) ? 8'd0 : 8'd255;
        return w;
    endfunction

    task automatic send_window(input win_t w, input int gap, output bit tmo);
        int n;
        tmo = 1'b0;
        for (int b = 0; b < 5; b++) begin
            n = 0;
            while (!rdyHeu && n < 100) begin @(posedge clk); #1; n++; end
            if (!rdyHeu) begin tmo = 1'b1; vldIpgu = 1'b0; return; end
            vldIpgu = 1'b1;
            ipguOutBufferQ = w[b];
            @(posedge clk); #1;
            vldIpgu = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic recv_window(output win_t got, output int lat, output bit tmo);
        int n;
        tmo = 1'b0; lat = -1; got = '0; rdyRnn = 1'b1;
        for (int b = 0; b < 5; b++) begin
            n = 0;
            while (!vldHeu && n < 3000) begin @(posedge clk); #1; n++; end
            if (!vldHeu) begin tmo = 1'b1; return; end
            if (b == 0) lat = cyc + 1 - acc_cyc;
            got[b] = heuOutBufferQ;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rdyHeu !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got %b want 0", rdyHeu); end
        n_cmp++; if (vldHeu !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", vldHeu); end
        n_cmp++; if (heuOutBufferQ !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", heuOutBufferQ); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++; if (rdyHeu !== 1'b0) begin n_bad++; $display("FAIL idle_rdy got %b want 0", rdyHeu); end
        @(posedge clk); #1;
        n_cmp++; if (rdyHeu !== 1'b1) begin n_bad++; $display("FAIL load_rdy got %b want 1", rdyHeu); end
    endtask

    task automatic test_constant();
        win_t w, got;
        int lat; bit tmo, rt;
        w = {400{8'h37}};
        send_window(w, 0, tmo);
        recv_window(got, lat, rt);
        n_cmp++; if (tmo || rt) begin n_bad++; $display("FAIL const_timeout got in=%0d out=%0d want 0", tmo, rt); end
        n_cmp++; if (lat !== 737) begin n_bad++; $display("FAIL const_latency got %0d want 737", lat); end
        for (int b = 0; b < 5; b++) begin
            n_cmp++;
            if (got[b] !== '0) begin n_bad++; $display("FAIL const_beat%0d got %h want 0", b, got[b]); end
        end
    endtask

    task automatic test_two_level();
        win_t got, ex;
        int lat; bit tmo, rt;
        ex = exp_two();
        send_window(mk_two(), 0, tmo);
        recv_window(got, lat, rt);
        n_cmp++; if (tmo || rt) begin n_bad++; $display("FAIL two_timeout got in=%0d out=%0d want 0", tmo, rt); end
        for (int b = 0; b < 5; b++) begin
            n_cmp++;
            if (got[b] !== ex[b]) begin n_bad++; $display("FAIL two_beat%0d got %h want %h", b, got[b], ex[b]); end
        end
    endtask

    task automatic test_ramp();
        win_t got, ex;
        int lat; bit tmo, rt;
        ex = exp_ramp();
        send_window(mk_ramp(), 0, tmo);
        recv_window(got, lat, rt);
        n_cmp++; if (tmo || rt) begin n_bad++; $display("FAIL ramp_timeout got in=%0d out=%0d want 0", tmo, rt); end
        n_cmp++; if (got[0][0] !== 8'd0)   begin n_bad++; $display("FAIL ramp_v0 got %0d want 0", got[0][0]); end
        n_cmp++; if (got[2][40] !== 8'd128) begin n_bad++; $display("FAIL ramp_v100 got %0d want 128", got[2][40]); end
        n_cmp++; if (got[4][78] !== 8'd255) begin n_bad++; $display("FAIL ramp_v199 got %0d want 255", got[4][78]); end
        for (int b = 0; b < 5; b++) begin
            n_cmp++;
            if (got[b] !== ex[b]) begin n_bad++; $display("FAIL ramp_beat%0d got %h want %h", b, got[b], ex[b]); end
        end
    endtask

    task automatic test_backpressure();
        win_t ex;
        logic [79:0][7:0] hold;
        int n, base; bit tmo, stable;
        ex = exp_ramp();
        base = n_out;
        send_window(mk_ramp(), 0, tmo);
        rdyRnn = 1'b1;
        for (int b = 0; b < 5; b++) begin
            n = 0;
            while (!vldHeu && n < 3000) begin
                @(posedge clk); #1; n++;
                if (b == 1) rdyRnn = ~rdyRnn;
            end
            if (b == 1) rdyRnn = 1'b0;
            n_cmp++;
            if (!vldHeu) begin n_bad++; $display("FAIL bp_wait%0d got vld=0 want 1", b); return; end
            if (b == 2) begin
                n_cmp++;
                if (cyc + 1 - out_cyc !== 81) begin
                    n_bad++; $display("FAIL bp_beat3_latency got %0d want 81", cyc + 1 - out_cyc);
                end
            end
            hold = heuOutBufferQ;
            if (b == 1) begin
                stable = 1'b1;
                repeat (50) begin
                    @(posedge clk); #1;
                    if (!vldHeu || heuOutBufferQ !== hold) stable = 1'b0;
                end
                n_cmp++; if (!stable) begin n_bad++; $display("FAIL bp_stable got 0 want 1"); end
                rdyRnn = 1'b1;
            end
            n_cmp++;
            if (hold !== ex[b]) begin n_bad++; $display("FAIL bp_beat%0d got %h want %h", b, hold, ex[b]); end
            @(posedge clk); #1;
        end
        n_cmp++; if (n_out - base !== 5) begin n_bad++; $display("FAIL bp_count got %0d want 5", n_out - base); end
    endtask

    task automatic test_pacing();
        win_t got, ex;
        int lat, base; bit tmo, rt, rdy_seen;
        ex = exp_ramp();
        base = n_acc;
        send_window(mk_ramp(), 3, tmo);
        vldIpgu = 1'b1;
        ipguOutBufferQ = {80{8'hFF}};
        rdy_seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (rdyHeu) rdy_seen = 1'b1;
        end
        vldIpgu = 1'b0;
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL pace_timeout got 1 want 0"); end
        n_cmp++; if (rdy_seen) begin n_bad++; $display("FAIL pace_rdy_in_hist got 1 want 0"); end
        n_cmp++; if (n_acc - base !== 5) begin n_bad++; $display("FAIL pace_accepts got %0d want 5", n_acc - base); end
        recv_window(got, lat, rt);
        n_cmp++; if (rt) begin n_bad++; $display("FAIL pace_out_timeout got 1 want 0"); end
        for (int b = 0; b < 5; b++) begin
            n_cmp++;
            if (got[b] !== ex[b]) begin n_bad++; $display("FAIL pace_beat%0d got %h want %h", b, got[b], ex[b]); end
        end
    endtask

    task automatic test_reset_mid();
        win_t got, ex;
        int lat, n; bit tmo, rt;
        ex = exp_ramp();
        rdyRnn = 1'b0;
        send_window(mk_two(), 0, tmo);
        n = 0;
        while (cyc - acc_cyc < 500 && n < 1000) begin @(posedge clk); #1; n++; end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rdyHeu !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rdy got %b want 0", rdyHeu); end
        n_cmp++; if (vldHeu !== 1'b0) begin n_bad++; $display("FAIL mid_rst_vld got %b want 0", vldHeu); end
        n_cmp++; if (heuOutBufferQ !== '0) begin n_bad++; $display("FAIL mid_rst_data got %h want 0", heuOutBufferQ); end
        @(posedge clk); #1 rst_n = 1'b1;
        send_window(mk_ramp(), 0, tmo);
        recv_window(got, lat, rt);
        n_cmp++; if (tmo || rt) begin n_bad++; $display("FAIL mid_timeout got in=%0d out=%0d want 0", tmo, rt); end
        n_cmp++; if (lat !== 737) begin n_bad++; $display("FAIL mid_latency got %0d want 737", lat); end
        for (int b = 0; b < 5; b++) begin
            n_cmp++;
            if (got[b] !== ex[b]) begin n_bad++; $display("FAIL mid_beat%0d got %h want %h", b, got[b], ex[b]); end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_two_level();
        test_ramp();
        test_backpressure();
        test_pacing();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/heu.md
Name: heu

Overview:
- Histogram-equalization unit, directly downstream of the image-pyramid generation unit (IPGU).
- Collects one 20x20 8-bit window from IPGU as 5 beats of 80 pixels.
- Builds a 256-bin histogram, then its cumulative distribution (CDF), then remaps every pixel with classic min-CDF equalization.
- Returns the equalized window to the downstream consumer as 5 beats of 80 pixels.

Parameters:
- PIX_W, 8, pixel width; fixed, the arithmetic below assumes 8.
- BEAT_PIX, 80, pixels per beat.
- NUM_BEATS, 5, beats per window; window = 400 pixels.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vldIpgu  in  1  IPGU beat valid; held until accepted
- ipguOutBufferQ  in  [79:0][7:0]  IPGU beat, pixel 0 first in raster order
- rdyHeu  out  1  HEU ready to accept an IPGU beat
- vldHeu  out  1  equalized beat valid
- heuOutBufferQ  out  [79:0][7:0]  equalized beat
- rdyRnn  in  1  downstream ready

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
- Transfer rule: a transfer occurs on a posedge where valid & ready are both 1, on either interface.
- Reset values: rdyHeu=0, vldHeu=0, heuOutBufferQ=0, all histogram bins=0, state=IDLE, all counters=0.
- Reset mid-operation: immediate return to reset values. Partial window discarded. No beat is replayed.
- States: IDLE, LOAD, HIST, CDF, MAP, OUT.
- IDLE: clears all 256 bins in one cycle. Next state is LOAD.
- LOAD:
  - rdyHeu=1, as a level.
  - Each transfer stores the beat into 400-pixel window buffer slot beat_cnt*80..+79, then increments beat_cnt.
  - The 5th transfer (cycle T) goes to HIST; rdyHeu drops at T+1.
- HIST: T+1..T+400. One pixel per cycle, index 0..399: bin[pix]++. Bins are 9-bit; max count 400, no overflow.
- CDF: T+401..T+656.
  - In-place prefix sum over bins 0..255.
  - cdf_min latches the first nonzero cdf value in ascending bin order.
- MAP: 80 cycles per beat, one pixel per cycle, writing heuOutBufferQ[k]. The first MAP spans T+657..T+736.
- Mapping, for pixel p with c=cdf[p]:
  - den = 400 - cdf_min (9 bits).
  - out = floor((c - cdf_min)*255 / den), using a 17-bit numerator.
  - If den==0 (constant window), out = 0.
  - Result is always ≤ 255; no saturation logic beyond an assertion.
- OUT:
  - vldHeu=1 from T+737, with heuOutBufferQ stable until transfer.
  - If the transfer happens at cycle S: vldHeu=0 at S+1.
  - If beats remain: MAP S+1..S+80, vldHeu=1 again at S+81.
  - After the 5th output transfer: IDLE.
- Backpressure: rdyRnn low holds vldHeu and data indefinitely. rdyRnn toggling while vldHeu=0 has no effect.
- rdyHeu is 0 in every state except LOAD. IPGU data presented outside LOAD is ignored.
- vldIpgu and rdyRnn are sampled only in their own states. Simultaneous assertion causes no interaction.
- Throughput: one window per ≥ 5 + 400 + 256 + 400 cycles, plus downstream stalls.

Test Plan:
- Constant window, all pixels 0x37, rdyRnn=1 -> 5 output beats, every pixel 0. First vldHeu exactly 737 cycles after the 5th input accept.
- Two-level window: pixels 0..199 = 10, pixels 200..399 = 50 -> outputs 0 for the first 200 pixels, 255 for the rest.
- Ramp window, pixel i = i>>1 (values 0..199) -> pixel value 0 maps to 0, 100 maps to 128, 199 maps to 255. Generally out = (2v*255)/398.
- Backpressure: hold rdyRnn=0 for 50 cycles at the 2nd output beat -> vldHeu and heuOutBufferQ stable throughout. Beat 3 is valid 81 cycles after the accept.
- Input pacing: vldIpgu gapped (1 cycle on, 3 off), plus vldIpgu=1 during HIST -> exactly 5 beats accepted. rdyHeu=0 after the 5th; no extra beats consumed.
- Reset asserted during CDF -> all outputs 0 asynchronously. After release, a new ramp window gives the correct result with no residue from the earlier bins.
